id_stage: RTL and testbench
===========================

Name: id_stage

Overview:
- RV32I instruction-decode stage that sits directly upstream of register_file.
- Takes fetched instructions over a valid/ready handshake and drives the register file read addresses.
- Bypasses same-cycle writeback data, generates immediates and control signals, and detects load-use hazards.
- Holds the result in an ID/EX pipeline register feeding the execute stage.

Parameters:
- XLEN, 32, datapath width of PC, operands and immediate.
- BYPASS_EN, 1, 1 = forward WD3 onto read operands when A3 matches and WE3=1; 0 = no bypass.

Ports:
- clk  in  1  clock, all state updates on rising edge
- rst  in  1  synchronous, active-high reset
- if_valid  in  1  fetch holds a valid instruction
- if_instr  in  32  instruction word
- if_pc  in  XLEN  PC of if_instr
- id_ready  out  1  stage accepts if_instr this cycle
- flush  in  1  kill ID/EX contents and drop the incoming instruction
- A1  out  5  register file read address 1 = if_instr[19:15]; 0 for LUI/JAL/AUIPC
- A2  out  5  register file read address 2 = if_instr[24:20]
- RD1  in  32  register file read data 1
- RD2  in  32  register file read data 2
- A3  in  5  writeback address, also seen by the register file
- WD3  in  32  writeback data
- WE3  in  1  writeback enable
- ex_ready  in  1  execute stage accepts ID/EX contents
- ex_valid  out  1  ID/EX register holds a valid instruction
- ex_pc  out  XLEN  registered PC
- ex_rs1_val, ex_rs2_val  out  XLEN  registered operands
- ex_imm  out  XLEN  registered sign-extended immediate
- ex_rd  out  5  destination register
- ex_alu_op  out  4  ALU operation code
- ex_alu_src  out  1  1 = operand B is immediate
- ex_mem_read, ex_mem_write, ex_reg_write, ex_branch, ex_jump, ex_illegal  out  1 each  control flags

Behaviour:
- Reset: ex_valid=0; every ex_* data and flag output = 0. A1/A2 are combinational from if_instr. id_ready=1 during rst.
- advance = !ex_valid || ex_ready.
- Hazard:
  - hazard = ex_valid && ex_mem_read && ex_rd!=0 && if_valid.
  - It additionally requires one of:
    - ex_rd==A1 and rs1 is used (all opcodes except LUI/AUIPC/JAL);
    - ex_rd==A2 and rs2 is used (R, STORE, BRANCH).
- id_ready = advance && !hazard, or flush=1.
- Capture: on rising edge with if_valid && id_ready && !flush, ID/EX loads the decoded instruction; ex_valid=1. Latency is 1 cycle from acceptance to ex_valid.
- Bubble: advance && (hazard || !if_valid) with !flush gives ex_valid=0 next cycle. Data fields may hold stale values; all ex_* flags are cleared.
- Hold: !advance keeps all ex_* outputs stable.
- Flush: ex_valid=0 and flags cleared next cycle. Flush overrides hold, hazard and capture. The incoming instruction is not captured.
- rst beats flush. rst mid-stall returns to the reset state with no residual stall.
- Operand bypass:
  - If BYPASS_EN && WE3 && A3!=0 && A3==A1, operand1 = WD3; otherwise RD1.
  - Same rule for operand2 with A2/RD2.
  - Operands read from x0 are always 0, regardless of RD1/RD2.
- Immediates, sign-extended from instr[31]:
  - I: instr[31:20]
  - S: instr[31:25],[11:7]
  - B: instr[31],[7],[30:25],[11:8],0
  - U: instr[31:12],12'b0
  - J: instr[31],[19:12],[20],[30:21],0
- Decode by opcode:
  - R (0110011): alu_op={f7[5],f3}; reg_write.
  - I-ALU (0010011): alu_op={f3==101?f7[5]:0, f3}; alu_src; reg_write.
  - LOAD (0000011): alu_op=0000; alu_src; mem_read; reg_write.
  - STORE (0100011): alu_op=0000; alu_src; mem_write; ex_rd=0.
  - BRANCH (1100011): alu_op=1000; branch; ex_rd=0.
  - JAL (1101111): jump; reg_write.
  - JALR (1100111): jump; alu_src; reg_write; alu_op=0000.
  - LUI (0110111): A1=0; alu_src; alu_op=0000; reg_write.
  - AUIPC (0010111): alu_src; alu_op=0000; reg_write.
  - Any other opcode: ex_illegal=1; reg_write/mem_read/mem_write/branch/jump all 0.
- rd==0: ex_reg_write is forced to 0.

Test Plan:
- Reset, then accept 0x00500093 (addi x1,x0,5) at PC 0x0 → next cycle: ex_valid=1, ex_imm=5, ex_rd=1, alu_src=1, reg_write=1, ex_rs1_val=0.
- WE3=1, A3=2, WD3=0x12345678, same cycle as add x3,x2,x1 (0x001101B3) with RD1=0 → ex_rs1_val=0x12345678. Repeat with BYPASS_EN=0 → 0.
- lw x5,0(x1) captured; next instr add x6,x5,x5 with ex_ready=1 → id_ready=0 for 1 cycle, bubble (ex_valid=0), then add captured.
- ex_ready=0 for 3 cycles while if_valid=1 → ex_* outputs constant, id_ready=0; release → next instruction captured on the following edge.
- flush=1 coincident with a hazard and if_valid=1 → next cycle ex_valid=0, no instruction captured; a following instruction is accepted with no stall.
- beq x1,x2,-8 (0xFE208CE3) → ex_imm=0xFFFFFFF8, branch=1, alu_op=1000. Opcode 0x7F → ex_illegal=1, reg_write=0.

Source files
------------

// File: rtl/id_stage.sv
// RV32I decode stage: register file addressing, writeback bypass, immediate
// generation, control decode, load-use hazard detection and the ID/EX register.
module id_stage #(
    parameter int unsigned XLEN      = 32,
    parameter bit          BYPASS_EN = 1'b1
) (
    input  logic            clk,
    input  logic            rst,
    // fetch side
    input  logic            if_valid,
    input  logic [31:0]     if_instr,
    input  logic [XLEN-1:0] if_pc,
    output logic            id_ready,
    input  logic            flush,
    // register file read ports
    output logic [4:0]      A1,
    output logic [4:0]      A2,
    input  logic [31:0]     RD1,
    input  logic [31:0]     RD2,
    // writeback, shared with the register file
    input  logic [4:0]      A3,
    input  logic [31:0]     WD3,
    input  logic            WE3,
    // execute side
    input  logic            ex_ready,
    output logic            ex_valid,
    output logic [XLEN-1:0] ex_pc,
    output logic [XLEN-1:0] ex_rs1_val,
    output logic [XLEN-1:0] ex_rs2_val,
    output logic [XLEN-1:0] ex_imm,
    output logic [4:0]      ex_rd,
    output logic [3:0]      ex_alu_op,
    output logic            ex_alu_src,
    output logic            ex_mem_read,
    output logic            ex_mem_write,
    output logic            ex_reg_write,
    output logic            ex_branch,
    output logic            ex_jump,
    output logic            ex_illegal
);

    localparam logic [6:0] OpR      = 7'b0110011;
    localparam logic [6:0] OpImm    = 7'b0010011;
    localparam logic [6:0] OpLoad   = 7'b0000011;
    localparam logic [6:0] OpStore  = 7'b0100011;
    localparam logic [6:0] OpBranch = 7'b1100011;
    localparam logic [6:0] OpJal    = 7'b1101111;
    localparam logic [6:0] OpJalr   = 7'b1100111;
    localparam logic [6:0] OpLui    = 7'b0110111;
    localparam logic [6:0] OpAuipc  = 7'b0010111;

    logic [6:0]  opcode;
    logic [2:0]  funct3;
    logic        funct7_b5;

    logic [31:0] imm_i, imm_s, imm_b, imm_u, imm_j;

    logic        dec_rs1_used, dec_rs2_used;
    logic [31:0] dec_imm;
    logic [4:0]  dec_rd;
    logic [3:0]  dec_alu_op;
    logic        dec_alu_src, dec_mem_read, dec_mem_write, dec_reg_write;
    logic        dec_branch, dec_jump, dec_illegal;

    logic [XLEN-1:0] op1, op2;
    logic            advance, hazard, capture;

    logic            ex_valid_q;
    logic [XLEN-1:0] ex_pc_q, ex_rs1_val_q, ex_rs2_val_q, ex_imm_q;
    logic [4:0]      ex_rd_q;
    logic [3:0]      ex_alu_op_q;
    logic            ex_alu_src_q, ex_mem_read_q, ex_mem_write_q, ex_reg_write_q;
    logic            ex_branch_q, ex_jump_q, ex_illegal_q;

    assign opcode    = if_instr[6:0];
    assign funct3    = if_instr[14:12];
    assign funct7_b5 = if_instr[30];

    assign imm_i = {{20{if_instr[31]}}, if_instr[31:20]};
    assign imm_s = {{20{if_instr[31]}}, if_instr[31:25], if_instr[11:7]};
    assign imm_b = {{19{if_instr[31]}}, if_instr[31], if_instr[7], if_instr[30:25],
                    if_instr[11:8], 1'b0};
    assign imm_u = {if_instr[31:12], 12'b0};
    assign imm_j = {{11{if_instr[31]}}, if_instr[31], if_instr[19:12], if_instr[20],
                    if_instr[30:21], 1'b0};

    // Opcode decode into control fields, immediate select and operand usage.
    always_comb begin
        dec_rs1_used  = 1'b1;
        dec_rs2_used  = 1'b0;
        dec_imm       = '0;
        dec_rd        = if_instr[11:7];
        dec_alu_op    = 4'b0000;
        dec_alu_src   = 1'b0;
        dec_mem_read  = 1'b0;
        dec_mem_write = 1'b0;
        dec_reg_write = 1'b0;
        dec_branch    = 1'b0;
        dec_jump      = 1'b0;
        dec_illegal   = 1'b0;
        case (opcode)
            OpR: begin
                dec_rs2_used  = 1'b1;
                dec_alu_op    = {funct7_b5, funct3};
                dec_reg_write = 1'b1;
            end
            OpImm: begin
                dec_imm       = imm_i;
                // Only the shift-right pair uses bit 30 to pick arithmetic vs logical.
                dec_alu_op    = {(funct3 == 3'b101) ? funct7_b5 : 1'b0, funct3};
                dec_alu_src   = 1'b1;
                dec_reg_write = 1'b1;
            end
            OpLoad: begin
                dec_imm       = imm_i;
                dec_alu_src   = 1'b1;
                dec_mem_read  = 1'b1;
                dec_reg_write = 1'b1;
            end
            OpStore: begin
                dec_rs2_used  = 1'b1;
                dec_imm       = imm_s;
                dec_alu_src   = 1'b1;
                dec_mem_write = 1'b1;
                dec_rd        = 5'd0;
            end
            OpBranch: begin
                dec_rs2_used  = 1'b1;
                dec_imm       = imm_b;
                dec_alu_op    = 4'b1000;
                dec_branch    = 1'b1;
                dec_rd        = 5'd0;
            end
            OpJal: begin
                dec_rs1_used  = 1'b0;
                dec_imm       = imm_j;
                dec_jump      = 1'b1;
                dec_reg_write = 1'b1;
            end
            OpJalr: begin
                dec_imm       = imm_i;
                dec_jump      = 1'b1;
                dec_alu_src   = 1'b1;
                dec_reg_write = 1'b1;
            end
            OpLui: begin
                dec_rs1_used  = 1'b0;
                dec_imm       = imm_u;
                dec_alu_src   = 1'b1;
                dec_reg_write = 1'b1;
            end
            OpAuipc: begin
                dec_rs1_used  = 1'b0;
                dec_imm       = imm_u;
                dec_alu_src   = 1'b1;
                dec_reg_write = 1'b1;
            end
            default: begin
                dec_illegal   = 1'b1;
            end
        endcase
        // Writes to x0 are architecturally discarded.
        if (dec_rd == 5'd0) begin
            dec_reg_write = 1'b0;
        end
    end

    assign A1 = dec_rs1_used ? if_instr[19:15] : 5'd0;
    assign A2 = if_instr[24:20];

    // Operand select: x0 reads as zero, otherwise same-cycle writeback wins over RD1/RD2.
    always_comb begin
        op1 = XLEN'(RD1);
        op2 = XLEN'(RD2);
        if (A1 == 5'd0) begin
            op1 = '0;
        end else if (BYPASS_EN && WE3 && (A3 == A1)) begin
            op1 = XLEN'(WD3);
        end
        if (A2 == 5'd0) begin
            op2 = '0;
        end else if (BYPASS_EN && WE3 && (A3 == A2)) begin
            op2 = XLEN'(WD3);
        end
    end

    assign advance  = !ex_valid_q || ex_ready;
    assign hazard   = ex_valid_q && ex_mem_read_q && (ex_rd_q != 5'd0) && if_valid &&
                      (((ex_rd_q == A1) && dec_rs1_used) || ((ex_rd_q == A2) && dec_rs2_used));
    assign id_ready = rst || flush || (advance && !hazard);
    assign capture  = advance && if_valid && !hazard;

    // ID/EX register: reset, then flush/bubble clear, then capture; otherwise hold.
    always_ff @(posedge clk) begin
        if (rst) begin
            ex_valid_q     <= 1'b0;
            ex_pc_q        <= '0;
            ex_rs1_val_q   <= '0;
            ex_rs2_val_q   <= '0;
            ex_imm_q       <= '0;
            ex_rd_q        <= 5'd0;
            ex_alu_op_q    <= 4'd0;
            ex_alu_src_q   <= 1'b0;
            ex_mem_read_q  <= 1'b0;
            ex_mem_write_q <= 1'b0;
            ex_reg_write_q <= 1'b0;
            ex_branch_q    <= 1'b0;
            ex_jump_q      <= 1'b0;
            ex_illegal_q   <= 1'b0;
        end else if (flush || (advance && !capture)) begin
            // Data fields are left stale; only validity and flags matter downstream.
            ex_valid_q     <= 1'b0;
            ex_alu_src_q   <= 1'b0;
            ex_mem_read_q  <= 1'b0;
            ex_mem_write_q <= 1'b0;
            ex_reg_write_q <= 1'b0;
            ex_branch_q    <= 1'b0;
            ex_jump_q      <= 1'b0;
            ex_illegal_q   <= 1'b0;
        end else if (capture) begin
            ex_valid_q     <= 1'b1;
            ex_pc_q        <= if_pc;
            ex_rs1_val_q   <= op1;
            ex_rs2_val_q   <= op2;
            ex_imm_q       <= XLEN'($signed(dec_imm));
            ex_rd_q        <= dec_rd;
            ex_alu_op_q    <= dec_alu_op;
            ex_alu_src_q   <= dec_alu_src;
            ex_mem_read_q  <= dec_mem_read;
            ex_mem_write_q <= dec_mem_write;
            ex_reg_write_q <= dec_reg_write;
            ex_branch_q    <= dec_branch;
            ex_jump_q      <= dec_jump;
            ex_illegal_q   <= dec_illegal;
        end
    end

    assign ex_valid     = ex_valid_q;
    assign ex_pc        = ex_pc_q;
    assign ex_rs1_val   = ex_rs1_val_q;
    assign ex_rs2_val   = ex_rs2_val_q;
    assign ex_imm       = ex_imm_q;
    assign ex_rd        = ex_rd_q;
    assign ex_alu_op    = ex_alu_op_q;
    assign ex_alu_src   = ex_alu_src_q;
    assign ex_mem_read  = ex_mem_read_q;
    assign ex_mem_write = ex_mem_write_q;
    assign ex_reg_write = ex_reg_write_q;
    assign ex_branch    = ex_branch_q;
    assign ex_jump      = ex_jump_q;
    assign ex_illegal   = ex_illegal_q;

endmodule

// File: tb/tb_id_stage.sv
// Bench for id_stage: directed scenarios plus randomized traffic, all checked
// against an arithmetic reference model of decode and the ID/EX pipeline slot.
module tb_id_stage;

    logic        clk = 1'b0;
    logic        rst, if_valid, flush, WE3, ex_ready;
    logic [31:0] if_instr, if_pc, RD1, RD2, WD3;
    logic [4:0]  A3;

    // bypassing instance
    logic        id_ready, ex_valid, ex_alu_src, ex_mem_read, ex_mem_write;
    logic        ex_reg_write, ex_branch, ex_jump, ex_illegal;
    logic [4:0]  A1, A2, ex_rd;
    logic [3:0]  ex_alu_op;
    logic [31:0] ex_pc, ex_rs1_val, ex_rs2_val, ex_imm;
    // non-bypassing instance
    logic        nb_id_ready, nb_ex_valid, nb_ex_alu_src, nb_ex_mem_read, nb_ex_mem_write;
    logic        nb_ex_reg_write, nb_ex_branch, nb_ex_jump, nb_ex_illegal;
    logic [4:0]  nb_A1, nb_A2, nb_ex_rd;
    logic [3:0]  nb_ex_alu_op;
    logic [31:0] nb_ex_pc, nb_ex_rs1_val, nb_ex_rs2_val, nb_ex_imm;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    id_stage #(.XLEN(32), .BYPASS_EN(1'b1)) dut (
        .clk(clk), .rst(rst), .if_valid(if_valid), .if_instr(if_instr), .if_pc(if_pc),
        .id_ready(id_ready), .flush(flush), .A1(A1), .A2(A2), .RD1(RD1), .RD2(RD2),
        .A3(A3), .WD3(WD3), .WE3(WE3), .ex_ready(ex_ready), .ex_valid(ex_valid),
        .ex_pc(ex_pc), .ex_rs1_val(ex_rs1_val), .ex_rs2_val(ex_rs2_val), .ex_imm(ex_imm),
        .ex_rd(ex_rd), .ex_alu_op(ex_alu_op), .ex_alu_src(ex_alu_src),
        .ex_mem_read(ex_mem_read), .ex_mem_write(ex_mem_write),
        .ex_reg_write(ex_reg_write), .ex_branch(ex_branch), .ex_jump(ex_jump),
        .ex_illegal(ex_illegal)
    );

    id_stage #(.XLEN(32), .BYPASS_EN(1'b0)) dut_nb (
        .clk(clk), .rst(rst), .if_valid(if_valid), .if_instr(if_instr), .if_pc(if_pc),
        .id_ready(nb_id_ready), .flush(flush), .A1(nb_A1), .A2(nb_A2), .RD1(RD1), .RD2(RD2),
        .A3(A3), .WD3(WD3), .WE3(WE3), .ex_ready(ex_ready), .ex_valid(nb_ex_valid),
        .ex_pc(nb_ex_pc), .ex_rs1_val(nb_ex_rs1_val), .ex_rs2_val(nb_ex_rs2_val),
        .ex_imm(nb_ex_imm), .ex_rd(nb_ex_rd), .ex_alu_op(nb_ex_alu_op),
        .ex_alu_src(nb_ex_alu_src), .ex_mem_read(nb_ex_mem_read),
        .ex_mem_write(nb_ex_mem_write), .ex_reg_write(nb_ex_reg_write),
        .ex_branch(nb_ex_branch), .ex_jump(nb_ex_jump), .ex_illegal(nb_ex_illegal)
    );

    typedef struct packed {
        logic [4:0]  a1, a2;
        logic        rs1_used, rs2_used;
        logic [31:0] imm;
        logic [4:0]  rd;
        logic [3:0]  alu_op;
        logic        alu_src, mem_read, mem_write, reg_write, branch, jump, illegal;
    } dec_t;

    typedef struct packed {
        logic        valid;
        logic [31:0] pc, rs1, rs2, rs1nb, rs2nb, imm;
        logic [4:0]  rd;
        logic [3:0]  alu_op;
        logic        alu_src, mem_read, mem_write, reg_write, branch, jump, illegal;
    } slot_t;

    slot_t      m = '0;
    logic [6:0] ops [10];

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got %h want %h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    // Immediates built by weighted sums of instruction fields.
    function automatic logic [31:0] ref_imm(input logic [31:0] ins, input byte fmt);
        int v;
        v = 0;
        case (fmt)
            "I": v = int'(ins[30:20]) - (ins[31] ? 2048 : 0);
            "S": v = int'(ins[30:25]) * 32 + int'(ins[11:7]) - (ins[31] ? 2048 : 0);
            "B": v = int'(ins[7]) * 2048 + int'(ins[30:25]) * 32 + int'(ins[11:8]) * 2
                     - (ins[31] ? 4096 : 0);
            "U": v = int'(ins[31:12]) * 4096;
            "J": v = int'(ins[19:12]) * 4096 + int'(ins[20]) * 2048 + int'(ins[30:21]) * 2
                     - (ins[31] ? 1048576 : 0);
            default: v = 0;
        endcase
        return 32'(v);
    endfunction

    function automatic dec_t ref_decode(input logic [31:0] ins);
        dec_t d;
        int   f3;
        f3 = int'(ins[14:12]);
        d = '0;
        d.rd = ins[11:7];
        d.a2 = ins[24:20];
        d.rs1_used = 1'b1;
        case (ins[6:0])
            7'h33: begin d.rs2_used = 1; d.alu_op = 4'(int'(ins[30]) * 8 + f3); d.reg_write = 1; end
            7'h13: begin
                d.imm = ref_imm(ins, "I"); d.alu_src = 1; d.reg_write = 1;
                d.alu_op = 4'((f3 == 5 && ins[30]) ? 8 + f3 : f3);
            end
            7'h03: begin d.imm = ref_imm(ins, "I"); d.alu_src = 1; d.mem_read = 1; d.reg_write = 1; end
            7'h23: begin d.rs2_used = 1; d.imm = ref_imm(ins, "S"); d.alu_src = 1; d.mem_write = 1; d.rd = 0; end
            7'h63: begin d.rs2_used = 1; d.imm = ref_imm(ins, "B"); d.alu_op = 4'd8; d.branch = 1; d.rd = 0; end
            7'h6F: begin d.rs1_used = 0; d.imm = ref_imm(ins, "J"); d.jump = 1; d.reg_write = 1; end
            7'h67: begin d.imm = ref_imm(ins, "I"); d.jump = 1; d.alu_src = 1; d.reg_write = 1; end
            7'h37, 7'h17: begin d.rs1_used = 0; d.imm = ref_imm(ins, "U"); d.alu_src = 1; d.reg_write = 1; end
            default: d.illegal = 1;
        endcase
        if (d.rd == 0) d.reg_write = 0;
        d.a1 = d.rs1_used ? ins[19:15] : 5'd0;
        return d;
    endfunction

    function automatic logic [31:0] ref_operand(input logic [4:0] a, input logic [31:0] rdata,
                                                input bit byp);
        if (a == 0) return 32'd0;
        if (byp && WE3 && A3 == a) return WD3;
        return rdata;
    endfunction

    task automatic drive(input logic v, input logic [31:0] ins, input logic [31:0] pc,
                         input logic rdy, input logic fl);
        rst = 0; if_valid = v; if_instr = ins; if_pc = pc; ex_ready = rdy; flush = fl;
        WE3 = 0; A3 = 5'($urandom_range(0, 31)); WD3 = $urandom; RD1 = $urandom; RD2 = $urandom;
    endtask

    // One clock: check combinational outputs mid-cycle, advance the model, check the slot.
    task automatic run_cycle();
        dec_t  d;
        slot_t nx;
        logic  adv, haz, take;
        @(negedge clk);
        d   = ref_decode(if_instr);
        adv = !m.valid || ex_ready;
        haz = m.valid && m.mem_read && m.rd != 0 && if_valid &&
              ((m.rd == d.a1 && d.rs1_used) || (m.rd == d.a2 && d.rs2_used));
        check_eq("id_ready", id_ready, rst || flush || (adv && !haz));
        check_eq("nb_id_ready", nb_id_ready, rst || flush || (adv && !haz));
        check_eq("A1", A1, d.a1);
        check_eq("A2", A2, d.a2);
        take = adv && if_valid && !haz;
        nx = m;
        if (rst) begin
            nx = '0;
        end else if (flush || (adv && !take)) begin
            nx.valid = 0; nx.alu_src = 0; nx.mem_read = 0; nx.mem_write = 0;
            nx.reg_write = 0; nx.branch = 0; nx.jump = 0; nx.illegal = 0;
        end else if (take) begin
            nx.valid = 1; nx.pc = if_pc; nx.imm = d.imm; nx.rd = d.rd; nx.alu_op = d.alu_op;
            nx.rs1 = ref_operand(d.a1, RD1, 1); nx.rs2 = ref_operand(d.a2, RD2, 1);
            nx.rs1nb = ref_operand(d.a1, RD1, 0); nx.rs2nb = ref_operand(d.a2, RD2, 0);
            nx.alu_src = d.alu_src; nx.mem_read = d.mem_read; nx.mem_write = d.mem_write;
            nx.reg_write = d.reg_write; nx.branch = d.branch; nx.jump = d.jump;
            nx.illegal = d.illegal;
        end
        @(posedge clk);
        #1;
        m = nx;
        check_eq("ex_valid", ex_valid, m.valid);
        check_eq("nb_ex_valid", nb_ex_valid, m.valid);
        check_eq("ex_mem_read", ex_mem_read, m.mem_read);
        check_eq("ex_mem_write", ex_mem_write, m.mem_write);
        check_eq("ex_reg_write", ex_reg_write, m.reg_write);
        check_eq("ex_branch", ex_branch, m.branch);
        check_eq("ex_jump", ex_jump, m.jump);
        check_eq("ex_illegal", ex_illegal, m.illegal);
        if (m.valid) begin
            check_eq("ex_pc", ex_pc, m.pc);
            check_eq("ex_imm", ex_imm, m.imm);
            check_eq("ex_rd", ex_rd, m.rd);
            check_eq("ex_alu_op", ex_alu_op, m.alu_op);
            check_eq("ex_alu_src", ex_alu_src, m.alu_src);
            check_eq("ex_rs1_val", ex_rs1_val, m.rs1);
            check_eq("ex_rs2_val", ex_rs2_val, m.rs2);
            check_eq("nb_ex_rs1_val", nb_ex_rs1_val, m.rs1nb);
            check_eq("nb_ex_rs2_val", nb_ex_rs2_val, m.rs2nb);
        end
    endtask

    function automatic logic [31:0] rand_instr();
        logic [31:0] ins;
        ins        = $urandom;
        ins[11:7]  = 5'($urandom_range(0, 7));
        ins[19:15] = 5'($urandom_range(0, 7));
        ins[24:20] = 5'($urandom_range(0, 7));
        ins[6:0]   = ops[$urandom_range(0, 9)];
        return ins;
    endfunction

    initial begin
        ops = '{7'h33, 7'h13, 7'h03, 7'h23, 7'h63, 7'h6F, 7'h67, 7'h37, 7'h17, 7'h7F};

        // reset with a valid instruction pending
        drive(1, 32'h00500093, 32'h0, 1, 0);
        rst = 1;
        @(posedge clk); #1;
        run_cycle();
        run_cycle();
        check_eq("rst_valid", ex_valid, 0);
        check_eq("rst_pc", ex_pc, 0);
        check_eq("rst_rs1", ex_rs1_val, 0);
        check_eq("rst_rs2", ex_rs2_val, 0);
        check_eq("rst_imm", ex_imm, 0);
        check_eq("rst_rd", ex_rd, 0);
        check_eq("rst_alu_op", ex_alu_op, 0);
        check_eq("rst_alu_src", ex_alu_src, 0);
        check_eq("rst_flags", {ex_mem_read, ex_mem_write, ex_reg_write, ex_branch, ex_jump,
                               ex_illegal}, 0);

        // addi x1,x0,5
        drive(1, 32'h00500093, 32'h0, 1, 0);
        run_cycle();
        check_eq("addi_valid", ex_valid, 1);
        check_eq("addi_imm", ex_imm, 5);
        check_eq("addi_rd", ex_rd, 1);
        check_eq("addi_alu_src", ex_alu_src, 1);
        check_eq("addi_reg_write", ex_reg_write, 1);
        check_eq("addi_rs1", ex_rs1_val, 0);

        // add x3,x2,x1 with same-cycle writeback to x2
        drive(1, 32'h001101B3, 32'h4, 1, 0);
        WE3 = 1; A3 = 5'd2; WD3 = 32'h12345678; RD1 = 32'h0;
        run_cycle();
        check_eq("bypass_rs1", ex_rs1_val, 32'h12345678);
        check_eq("nobypass_rs1", nb_ex_rs1_val, 32'h0);

        // lw x5,0(x1) then dependent add x6,x5,x5
        drive(1, 32'h0000A283, 32'h8, 1, 0);
        run_cycle();
        drive(1, 32'h00528333, 32'hC, 1, 0);
        #1 check_eq("loaduse_ready", id_ready, 0);
        run_cycle();
        check_eq("loaduse_bubble", ex_valid, 0);
        #1 check_eq("loaduse_ready2", id_ready, 1);
        run_cycle();
        check_eq("loaduse_capture", ex_valid, 1);
        check_eq("loaduse_rd", ex_rd, 6);

        // addi x7,x1,7 then execute stalls for 3 cycles
        drive(1, 32'h00708393, 32'h10, 1, 0);
        run_cycle();
        for (int i = 0; i < 3; i++) begin
            drive(1, 32'h001101B3, 32'h14, 0, 0);
            #1 check_eq("hold_ready", id_ready, 0);
            run_cycle();
            check_eq("hold_pc", ex_pc, 32'h10);
            check_eq("hold_imm", ex_imm, 7);
        end
        drive(1, 32'h001101B3, 32'h14, 1, 0);
        run_cycle();
        check_eq("release_pc", ex_pc, 32'h14);

        // flush over a load-use hazard
        drive(1, 32'h0000A283, 32'h18, 1, 0);
        run_cycle();
        drive(1, 32'h00528333, 32'h1C, 1, 1);
        #1 check_eq("flush_ready", id_ready, 1);
        run_cycle();
        check_eq("flush_valid", ex_valid, 0);
        drive(1, 32'h00528333, 32'h20, 1, 0);
        #1 check_eq("postflush_ready", id_ready, 1);
        run_cycle();
        check_eq("postflush_valid", ex_valid, 1);
        check_eq("postflush_pc", ex_pc, 32'h20);

        // beq x1,x2,-8 and an illegal opcode
        drive(1, 32'hFE208CE3, 32'h24, 1, 0);
        run_cycle();
        check_eq("beq_imm", ex_imm, 32'hFFFFFFF8);
        check_eq("beq_branch", ex_branch, 1);
        check_eq("beq_alu_op", ex_alu_op, 4'b1000);
        check_eq("beq_rd", ex_rd, 0);
        drive(1, 32'h000000FF, 32'h28, 1, 0);
        run_cycle();
        check_eq("ill_illegal", ex_illegal, 1);
        check_eq("ill_reg_write", ex_reg_write, 0);

        // randomized traffic
        for (int i = 0; i < 3000; i++) begin
            drive($urandom_range(0, 4) != 0, rand_instr(), $urandom,
                  $urandom_range(0, 9) < 7, $urandom_range(0, 19) == 0);
            rst = ($urandom_range(0, 199) == 0);
            WE3 = 1'($urandom_range(0, 1));
            A3  = 5'($urandom_range(0, 7));
            run_cycle();
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
